// File: rtl/sw_req_capture_if.sv
// Request-capture bus: raw switch levels, enable and ack in; sticky pending
// requests, encoder enable, popcount and ack error out.
interface sw_req_capture_if #(
    parameter int N = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = $clog2(N) + 1;

    logic [N-1:0]  sw_in;
    logic          en_in;
    logic          ack;
    logic [IW-1:0] ack_idx;
    logic [N-1:0]  pend;
    logic          pend_en;
    logic [PW-1:0] pend_cnt;
    logic          ack_err;

    modport master (
        output sw_in, en_in, ack, ack_idx,
        input  pend, pend_en, pend_cnt, ack_err
    );

    modport slave (
        input  sw_in, en_in, ack, ack_idx,
        output pend, pend_en, pend_cnt, ack_err
    );
endinterface

// File: rtl/sw_req_capture.sv
// Front end for the 8-to-3 priority encoder: synchronises and debounces raw
// switch lines, turns each debounced press into a sticky pending bit, and
// retires pending bits one at a time through an indexed ack.
module sw_req_capture #(
    parameter int N       = 8,
    parameter int DEB_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sw_req_capture_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(DEB_CYC) + 1;
    localparam int PW = $clog2(N) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);
    localparam logic [IW:0]   IDX_LIM  = (IW + 1)'(N);

    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [N-1:0]  stable;
    logic [N-1:0]  stable_nxt;
    logic [N-1:0]  set_mask;
    logic [CW-1:0] cnt     [N];
    logic [CW-1:0] cnt_nxt [N];

    logic [N-1:0]  pend_r;
    logic [N-1:0]  pend_nxt;
    logic [N-1:0]  clr_mask;
    logic          ack_hit;
    logic          ack_in_range;
    logic          ack_err_r;
    logic          pend_en_r;
    logic [PW-1:0] pop;

    // Two-flop synchroniser; s1 feeds nothing but s2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.sw_in;
            s2 <= s1;
        end
    end

    // Per-bit debounce: a level change is accepted only after DEB_CYC
    // consecutive cycles of disagreement; any agreeing cycle restarts the count.
    always_comb begin
        stable_nxt = stable;
        set_mask   = '0;
        for (int i = 0; i < N; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i] = s2[i];
                    set_mask[i]   = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            stable <= stable_nxt;
            for (int i = 0; i < N; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    // Pending update: a debounced rise sets, an in-range ack clears, and a
    // rise on the acked bit wins over the clear. An ack counts as valid when
    // the bit is pending or is being set on this same edge.
    always_comb begin
        ack_in_range = ({1'b0, bus.ack_idx} < IDX_LIM);
        clr_mask     = '0;
        ack_hit      = 1'b0;
        if (bus.ack && ack_in_range) begin
            clr_mask[bus.ack_idx] = 1'b1;
            ack_hit = pend_r[bus.ack_idx] | set_mask[bus.ack_idx];
        end
        pend_nxt = (pend_r & ~clr_mask) | set_mask;
    end

    // Pending register, encoder enable and one-cycle ack error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r    <= '0;
            pend_en_r <= 1'b0;
            ack_err_r <= 1'b0;
        end else begin
            pend_r    <= pend_nxt;
            pend_en_r <= bus.en_in & (|pend_nxt);
            ack_err_r <= bus.ack & ~ack_hit;
        end
    end

    // Number of pending requests, straight off the register.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) pop = pop + PW'(pend_r[i]);
    end

    assign bus.pend     = pend_r;
    assign bus.pend_en  = pend_en_r;
    assign bus.ack_err  = ack_err_r;
    assign bus.pend_cnt = pop;
endmodule

// File: tb/tb_sw_req_capture.sv
// Bench for sw_req_capture: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a window-based
// behavioural model.
module tb_sw_req_capture;
    localparam int N = 8;
    localparam int D = 4;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    sw_req_capture_if #(.N(N)) bus ();

    sw_req_capture #(.N(N), .DEB_CYC(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[k] holds the raw input sampled k+1 edges ago. The synchroniser
    // delays by two edges, so a debounced level flips when the DEB_CYC most
    // recent synchronised samples (hist[1..D]) all disagree with it.
    logic [N-1:0] m_hist [D+1];
    logic [N-1:0] m_stable, m_pend;
    logic         m_en, m_err;
    logic [N-1:0] w_flip, w_rise, n_stable, n_pend;
    logic         n_err, n_en;

    always_comb begin
        w_flip = '1;
        for (int k = 1; k <= D; k++) w_flip = w_flip & (m_hist[k] ^ m_stable);
        w_rise   = w_flip & ~m_stable;
        n_stable = m_stable ^ w_flip;
        n_pend   = m_pend;
        n_err    = bus.ack;
        for (int i = 0; i < N; i++) begin
            if (w_rise[i]) n_pend[i] = 1'b1;
            else if (bus.ack && int'(bus.ack_idx) == i) n_pend[i] = 1'b0;
            if (bus.ack && int'(bus.ack_idx) == i && (m_pend[i] || w_rise[i])) n_err = 1'b0;
        end
        n_en = bus.en_in && (n_pend != '0);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= D; k++) m_hist[k] <= '0;
            m_stable <= '0;
            m_pend   <= '0;
            m_en     <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            m_hist[0] <= bus.sw_in;
            for (int k = 1; k <= D; k++) m_hist[k] <= m_hist[k-1];
            m_stable <= n_stable;
            m_pend   <= n_pend;
            m_en     <= n_en;
            m_err    <= n_err;
        end
    end

    // Cycle-by-cycle compare, away from the active edge.
    always @(negedge clk) begin
        chk("m_pend",     32'(bus.pend),     32'(m_pend));
        chk("m_pend_en",  32'(bus.pend_en),  32'(m_en));
        chk("m_pend_cnt", 32'(bus.pend_cnt), 32'($countones(m_pend)));
        chk("m_ack_err",  32'(bus.ack_err),  32'(m_err));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_ack(input int idx);
        bus.ack     = 1'b1;
        bus.ack_idx = 3'(idx);
        tick(1);
        bus.ack     = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b1;
        bus.sw_in   = '0;
        bus.en_in   = 1'b1;
        bus.ack     = 1'b0;
        bus.ack_idx = '0;
        #1 rst_n = 1'b0;

        // T1: reset holds everything at zero despite active inputs
        bus.sw_in = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            bus.ack     = 1'($urandom_range(0, 1));
            bus.ack_idx = 3'($urandom_range(0, 7));
            tick(1);
            chk("t1_pend", 32'(bus.pend), 32'h0);
            chk("t1_err",  32'(bus.ack_err), 32'h0);
            chk("t1_en",   32'(bus.pend_en), 32'h0);
            chk("t1_cnt",  32'(bus.pend_cnt), 32'h0);
        end
        bus.ack   = 1'b0;
        bus.sw_in = '0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // T2: single press on bit 5, visible after edge 5 only
        bus.sw_in = 8'h20;
        tick(5);
        chk("t2_pend_e4", 32'(bus.pend), 32'h00);
        tick(1);
        chk("t2_pend_e5", 32'(bus.pend), 32'h20);
        chk("t2_en",      32'(bus.pend_en), 32'h1);
        chk("t2_cnt",     32'(bus.pend_cnt), 32'h1);

        // T3: 3-cycle glitch rejected, 4-cycle pulse accepted, long hold sets once
        bus.sw_in = 8'h24;
        tick(3);
        bus.sw_in = 8'h20;
        tick(10);
        chk("t3_glitch", 32'(bus.pend), 32'h20);
        bus.sw_in = 8'h24;
        tick(4);
        bus.sw_in = 8'h20;
        tick(8);
        chk("t3_pulse", 32'(bus.pend), 32'h24);
        do_ack(5);
        do_ack(2);
        chk("t3_clr", 32'(bus.pend), 32'h00);
        bus.sw_in = 8'h24;
        tick(20);
        chk("t3_hold_set", 32'(bus.pend), 32'h04);
        do_ack(2);
        tick(80);
        chk("t3_hold_once", 32'(bus.pend), 32'h00);
        bus.sw_in = 8'h00;
        tick(10);

        // T4: ack flow and ack to an empty slot
        bus.sw_in = 8'h81;
        tick(10);
        bus.sw_in = 8'h00;
        tick(10);
        chk("t4_pend", 32'(bus.pend), 32'h81);
        chk("t4_cnt",  32'(bus.pend_cnt), 32'h2);
        do_ack(7);
        chk("t4_ack7", 32'(bus.pend), 32'h01);
        chk("t4_en1",  32'(bus.pend_en), 32'h1);
        do_ack(0);
        chk("t4_ack0", 32'(bus.pend), 32'h00);
        chk("t4_en0",  32'(bus.pend_en), 32'h0);
        chk("t4_noerr", 32'(bus.ack_err), 32'h0);
        do_ack(3);
        chk("t4_err",  32'(bus.ack_err), 32'h1);
        chk("t4_keep", 32'(bus.pend), 32'h00);
        tick(1);
        chk("t4_err_pulse", 32'(bus.ack_err), 32'h0);

        // T5: ack on the edge the same bit is set again
        bus.sw_in = 8'h10;
        tick(10);
        chk("t5_set", 32'(bus.pend), 32'h10);
        bus.sw_in = 8'h00;
        tick(10);
        bus.sw_in = 8'h10;
        tick(5);
        bus.ack     = 1'b1;
        bus.ack_idx = 3'd4;
        tick(1);
        bus.ack = 1'b0;
        chk("t5_pend", 32'(bus.pend), 32'h10);
        chk("t5_err",  32'(bus.ack_err), 32'h0);

        // T6: enable gating, then reset during a debounce
        bus.en_in = 1'b0;
        tick(1);
        chk("t6_en_off", 32'(bus.pend_en), 32'h0);
        chk("t6_hold",   32'(bus.pend), 32'h10);
        bus.en_in = 1'b1;
        tick(1);
        chk("t6_en_on", 32'(bus.pend_en), 32'h1);
        bus.sw_in = 8'h12;
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pend", 32'(bus.pend), 32'h00);
        chk("t6_rst_cnt",  32'(bus.pend_cnt), 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        chk("t6_pre", 32'(bus.pend), 32'h00);
        tick(1);
        chk("t6_reset_press", 32'(bus.pend), 32'h12);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0)
                bus.sw_in = bus.sw_in ^ (8'h01 << $urandom_range(0, 7));
            bus.ack     = ($urandom_range(0, 2) == 0);
            bus.ack_idx = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) bus.en_in = ~bus.en_in;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
            tick(1);
        end
        bus.ack = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
